// File: rtl/sdram_arbiter_if.sv
// Request/command bundle between the frame read/write paths, the arbiter and the SDRAM engine.
// The arbiter takes the slave side; the requesters and engine take the master side.
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_W = 22
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              cmd_vld;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rdy;
  logic              op_done;
  logic              wr_gnt;
  logic              rd_gnt;

  modport slave (
    input  wr_req, wr_addr, rd_req, rd_addr, cmd_rdy, op_done,
    output cmd_vld, cmd_type, cmd_addr, wr_gnt, rd_gnt
  );

  modport master (
    output wr_req, wr_addr, rd_req, rd_addr, cmd_rdy, op_done,
    input  cmd_vld, cmd_type, cmd_addr, wr_gnt, rd_gnt
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Single-command-engine SDRAM scheduler: refresh first, then round-robin between the
// frame-write and frame-read paths, one operation in flight at a time.
module sdram_arbiter #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned REF_PERIOD = 780
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  sdram_arbiter_if.slave   bus,
  output logic             busy,
  output logic             ref_ovf
);

  localparam int unsigned CntW   = $clog2(REF_PERIOD);
  localparam logic [CntW-1:0] RefMax = CntW'(REF_PERIOD - 1);

  localparam logic [1:0] CmdRef = 2'b00;
  localparam logic [1:0] CmdWr  = 2'b01;
  localparam logic [1:0] CmdRd  = 2'b10;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              ref_ovf_q, ref_ovf_d;
  logic              last_wr_q, last_wr_d;
  logic              cmd_vld_q, cmd_vld_d;
  logic [1:0]        cmd_type_q, cmd_type_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              busy_q, busy_d;
  logic              wrap, ref_hs;

  // Refresh timer; a wrap that lands on the clearing handshake still leaves a refresh pending.
  always_comb begin
    wrap       = init_done && (ref_cnt_q == RefMax);
    ref_hs     = cmd_vld_q && bus.cmd_rdy && (cmd_type_q == CmdRef);
    ref_cnt_d  = (!init_done || wrap) ? '0 : ref_cnt_q + CntW'(1);
    ref_pend_d = wrap ? 1'b1 : (ref_hs ? 1'b0 : ref_pend_q);
    ref_ovf_d  = ref_ovf_q | (wrap & ref_pend_q);
  end

  always_comb begin
    state_d    = state_q;
    cmd_type_d = cmd_type_q;
    cmd_addr_d = cmd_addr_q;
    last_wr_d  = last_wr_q;
    wr_gnt_d   = 1'b0;
    rd_gnt_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init_done) begin
          if (ref_pend_q) begin
            state_d    = StIssue;
            cmd_type_d = CmdRef;
            cmd_addr_d = '0;
          end else if (bus.wr_req && (!bus.rd_req || !last_wr_q)) begin
            state_d    = StIssue;
            cmd_type_d = CmdWr;
            cmd_addr_d = bus.wr_addr;
          end else if (bus.rd_req) begin
            state_d    = StIssue;
            cmd_type_d = CmdRd;
            cmd_addr_d = bus.rd_addr;
          end
        end
      end
      StIssue: begin
        if (bus.cmd_rdy) begin
          state_d = StWait;
          if (cmd_type_q == CmdWr) begin
            wr_gnt_d  = 1'b1;
            last_wr_d = 1'b1;
          end else if (cmd_type_q == CmdRd) begin
            rd_gnt_d  = 1'b1;
            last_wr_d = 1'b0;
          end
        end
      end
      StWait: begin
        if (bus.op_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cmd_vld_d = (state_d == StIssue);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      ref_ovf_q  <= 1'b0;
      last_wr_q  <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_type_q <= CmdRef;
      cmd_addr_q <= '0;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ref_ovf_q  <= ref_ovf_d;
      last_wr_q  <= last_wr_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_type_q <= cmd_type_d;
      cmd_addr_q <= cmd_addr_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cmd_vld  = cmd_vld_q;
  assign bus.cmd_type = cmd_type_q;
  assign bus.cmd_addr = cmd_addr_q;
  assign bus.wr_gnt   = wr_gnt_q;
  assign bus.rd_gnt   = rd_gnt_q;
  assign busy         = busy_q;
  assign ref_ovf      = ref_ovf_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a long-period and a short-period instance share stimulus; a
// scoreboard of expected read/write commands is checked at every command handshake.
module tb_sdram_arbiter;
  localparam int unsigned AW = 22;

  typedef struct packed {
    logic [1:0]    t;
    logic [AW-1:0] a;
  } cmd_t;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [1:0]    t;
    logic [AW-1:0] a;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0, cmd_rdy = 1'b0;
  logic eng_done = 1'b0, stray_done = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic busy_l, busy_s, ovf_l, ovf_s;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(AW)) bus_l ();
  sdram_arbiter_if #(.ADDR_W(AW)) bus_s ();

  assign bus_l.wr_req  = wr_req;   assign bus_s.wr_req  = wr_req;
  assign bus_l.wr_addr = wr_addr;  assign bus_s.wr_addr = wr_addr;
  assign bus_l.rd_req  = rd_req;   assign bus_s.rd_req  = rd_req;
  assign bus_l.rd_addr = rd_addr;  assign bus_s.rd_addr = rd_addr;
  assign bus_l.cmd_rdy = cmd_rdy;  assign bus_s.cmd_rdy = cmd_rdy;
  assign bus_l.op_done = eng_done | stray_done;
  assign bus_s.op_done = eng_done | stray_done;

  sdram_arbiter #(.ADDR_W(AW), .REF_PERIOD(1000)) u_long (
    .clk(clk), .rst(rst), .init_done(init_done), .bus(bus_l.slave),
    .busy(busy_l), .ref_ovf(ovf_l)
  );

  sdram_arbiter #(.ADDR_W(AW), .REF_PERIOD(16)) u_short (
    .clk(clk), .rst(rst), .init_done(init_done), .bus(bus_s.slave),
    .busy(busy_s), .ref_ovf(ovf_s)
  );

  // Observed instance: 0 = long period, 1 = short period.
  logic          sel = 1'b0;
  logic          m_vld, m_wgnt, m_rgnt, m_busy, m_ovf;
  logic [1:0]    m_type;
  logic [AW-1:0] m_addr;

  always_comb begin
    m_vld  = sel ? bus_s.cmd_vld  : bus_l.cmd_vld;
    m_type = sel ? bus_s.cmd_type : bus_l.cmd_type;
    m_addr = sel ? bus_s.cmd_addr : bus_l.cmd_addr;
    m_wgnt = sel ? bus_s.wr_gnt   : bus_l.wr_gnt;
    m_rgnt = sel ? bus_s.rd_gnt   : bus_l.rd_gnt;
    m_busy = sel ? busy_s         : busy_l;
    m_ovf  = sel ? ovf_s          : ovf_l;
  end

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_hs_cyc = -1;
  int   gap_exp = 0;
  int   ref_seen = 0;
  int   op_delay = 1;
  logic chk_gap = 1'b0;
  logic eng_en = 1'b1;
  cmd_t exp_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on handshake, grant pulse and turnaround checks.
  initial begin
    logic       hs_prev;
    logic [1:0] prev_t;
    cmd_t       e;
    hs_prev = 1'b0;
    prev_t  = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (hs_prev || m_wgnt || m_rgnt) begin
        check("wr_gnt", m_wgnt, hs_prev && prev_t == 2'b01);
        check("rd_gnt", m_rgnt, hs_prev && prev_t == 2'b10);
      end
      hs_prev = 1'b0;
      if (!rst && m_vld && cmd_rdy) begin
        hs_prev = 1'b1;
        prev_t  = m_type;
        if (m_type == 2'b00) begin
          ref_seen++;
          check("ref_addr", m_addr, 0);
        end else begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cmd: got type %0h addr %0h want none", m_type, m_addr);
          end else begin
            e = exp_q.pop_front();
            check("cmd_type", m_type, e.t);
            check("cmd_addr", m_addr, e.a);
          end
          if (chk_gap && last_hs_cyc >= 0) check("turnaround", cyc - last_hs_cyc, gap_exp);
          last_hs_cyc = cyc;
        end
      end
    end
  end

  // Engine model: op_done pulses op_delay cycles after each accepted command.
  initial begin
    forever begin
      @(negedge clk);
      if (eng_en && !rst && m_vld && cmd_rdy) begin
        @(posedge clk);
        #1;
        repeat (op_delay - 1) begin
          @(posedge clk);
          #1;
        end
        eng_done = 1'b1;
        @(posedge clk);
        #1;
        eng_done = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic wait_vld(input int max, input string name);
    int i;
    i = 0;
    while (!m_vld && i < max) begin
      tick(1);
      i++;
    end
    check({name, "_vld"}, m_vld, 1);
  endtask

  task automatic drain(input int max, input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_busy) && i < max) begin
      tick(1);
      i++;
    end
    check({name, "_drain"}, exp_q.size() + 32'(m_busy), 0);
  endtask

  task automatic push(input logic [1:0] t, input logic [AW-1:0] a);
    cmd_t e;
    e.t = t;
    e.a = a;
    exp_q.push_back(e);
  endtask

  initial begin
    logic seen_vld;
    int   delays[2];
    int   i;
    delays[0] = 1;
    delays[1] = 4;

    vecs[0] = '{1'b1, 1'b0, 22'h000100, 22'h000000, 2'b01, 22'h000100};
    vecs[1] = '{1'b0, 1'b1, 22'h000000, 22'h000200, 2'b10, 22'h000200};
    vecs[2] = '{1'b1, 1'b1, 22'h000003, 22'h000004, 2'b01, 22'h000003};
    vecs[3] = '{1'b1, 1'b1, 22'h000005, 22'h000006, 2'b10, 22'h000006};
    vecs[4] = '{1'b1, 1'b1, 22'h3FFFFF, 22'h2AAAAA, 2'b01, 22'h3FFFFF};
    vecs[5] = '{1'b0, 1'b1, 22'h000000, 22'h155555, 2'b10, 22'h155555};
    vecs[6] = '{1'b0, 1'b1, 22'h000000, 22'h000007, 2'b10, 22'h000007};
    vecs[7] = '{1'b1, 1'b1, 22'h000008, 22'h000009, 2'b01, 22'h000008};
    vecs[8] = '{1'b1, 1'b0, 22'h00000A, 22'h000000, 2'b01, 22'h00000A};
    vecs[9] = '{1'b1, 1'b1, 22'h00000B, 22'h00000C, 2'b10, 22'h00000C};

    // Reset values and init gating.
    sel = 1'b0;
    cmd_rdy = 1'b1;
    wr_req = 1'b1;
    wr_addr = 22'h012345;
    rst = 1'b1;
    tick(3);
    check("rst_vld", m_vld, 0);
    check("rst_type", m_type, 0);
    check("rst_addr", m_addr, 0);
    check("rst_gnt", {m_wgnt, m_rgnt}, 0);
    check("rst_busy", m_busy, 0);
    check("rst_ovf", m_ovf, 0);
    rst = 1'b0;
    seen_vld = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      seen_vld = seen_vld | bus_l.cmd_vld | bus_s.cmd_vld;
    end
    check("no_cmd_before_init", seen_vld, 0);
    check("ref_held_short_ovf", ovf_s, 0);
    push(2'b01, 22'h012345);
    init_done = 1'b1;
    check("vld_before_sample", m_vld, 0);
    tick(1);
    check("vld_latency", m_vld, 1);
    wr_req = 1'b0;
    drain(20, "init_write");

    // Table-driven single transactions from IDLE.
    do_reset();
    op_delay = 1;
    for (int k = 0; k < 10; k++) begin
      wr_req = vecs[k].wr;
      rd_req = vecs[k].rd;
      wr_addr = vecs[k].wa;
      rd_addr = vecs[k].ra;
      push(vecs[k].t, vecs[k].a);
      wait_vld(10, "vec");
      wr_req = 1'b0;
      rd_req = 1'b0;
      drain(20, "vec");
    end

    // Continuous contention: strict alternation and fixed turnaround.
    for (int d = 0; d < 2; d++) begin
      do_reset();
      op_delay = delays[d];
      gap_exp = delays[d] + 2;
      last_hs_cyc = -1;
      chk_gap = 1'b1;
      wr_addr = 22'h111111;
      rd_addr = 22'h222222;
      for (int k = 0; k < 8; k++) push((k % 2 == 0) ? 2'b01 : 2'b10,
                                       (k % 2 == 0) ? 22'h111111 : 22'h222222);
      wr_req = 1'b1;
      rd_req = 1'b1;
      i = 0;
      while (exp_q.size() != 0 && i < 200) begin
        tick(1);
        i++;
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      chk_gap = 1'b0;
      drain(20, "rr");
    end

    // Refresh priority on the short-period instance.
    rst = 1'b1;
    sel = 1'b1;
    do_reset();
    op_delay = 1;
    ref_seen = 0;
    wr_addr = 22'h0F0F0F;
    rd_addr = 22'h303030;
    for (int k = 0; k < 12; k++) push((k % 2 == 0) ? 2'b01 : 2'b10,
                                      (k % 2 == 0) ? 22'h0F0F0F : 22'h303030);
    wr_req = 1'b1;
    rd_req = 1'b1;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      tick(1);
      i++;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    drain(20, "refresh");
    check("refresh_served", ref_seen >= 2, 1);
    check("refresh_no_ovf", m_ovf, 0);

    // Back-pressure on the long instance.
    rst = 1'b1;
    sel = 1'b0;
    do_reset();
    cmd_rdy = 1'b0;
    wr_req = 1'b1;
    wr_addr = 22'h0ABCDE;
    push(2'b01, 22'h0ABCDE);
    wait_vld(10, "bp");
    wr_req = 1'b0;
    wr_addr = 22'h3FFFFF;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("bp_vld", m_vld, 1);
      check("bp_addr", m_addr, 22'h0ABCDE);
      check("bp_type", m_type, 2'b01);
    end
    cmd_rdy = 1'b1;
    drain(20, "bp");

    // Refresh overrun on the short instance.
    rst = 1'b1;
    sel = 1'b1;
    init_done = 1'b0;
    do_reset();
    cmd_rdy = 1'b0;
    init_done = 1'b1;
    tick(20);
    check("ovf_first_wrap", m_ovf, 0);
    check("ovf_ref_vld", m_vld, 1);
    tick(20);
    check("ovf_second_wrap", m_ovf, 1);
    check("ovf_ref_type", m_type, 2'b00);
    cmd_rdy = 1'b1;
    tick(10);
    check("ovf_sticky", m_ovf, 1);
    drain(20, "ovf");
    do_reset();
    check("ovf_cleared", m_ovf, 0);

    // Reset in WAIT, stray op_done, then first contested grant is a write.
    sel = 1'b0;
    do_reset();
    eng_en = 1'b0;
    cmd_rdy = 1'b1;
    wr_req = 1'b1;
    wr_addr = 22'h055AA5;
    push(2'b01, 22'h055AA5);
    wait_vld(10, "midrst");
    wr_req = 1'b0;
    tick(2);
    check("midrst_in_wait", m_busy, 1);
    rst = 1'b1;
    tick(1);
    check("midrst_busy", m_busy, 0);
    check("midrst_vld", m_vld, 0);
    rst = 1'b0;
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    tick(2);
    check("stray_done_busy", m_busy, 0);
    eng_en = 1'b1;
    wr_addr = 22'h000111;
    rd_addr = 22'h000222;
    push(2'b01, 22'h000111);
    wr_req = 1'b1;
    rd_req = 1'b1;
    wait_vld(10, "post_rst");
    wr_req = 1'b0;
    rd_req = 1'b0;
    drain(20, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
